char_blitter: RTL and testbench
===============================

Name: char_blitter

Overview:
- Sequential driver for the per-character glyph decoders (char_k and siblings).
- On a start pulse it latches a character origin and code, then walks every pixel of the CELL_W x CELL_H cell in row-major order.
- For each pixel it presents absolute scan coordinates to the decoder bank, samples the returned enable/colour, and emits plot writes to the VGA adapter over a valid/ready handshake.
- It sits between the text/sprite control FSM and the VGA adapter.

Parameters:
- CELL_W, 8, cell width in pixels; scan dx runs 0..CELL_W-1.
- CELL_H, 10, cell height in pixels; scan dy runs 0..CELL_H-1.
- CLEAR_BG, 0, when 1, pixels with glyph_enable=0 are also plotted, using BG_COLOUR.
- BG_COLOUR, 6'b000000, colour for background plots when CLEAR_BG=1.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a blit; accepted only in IDLE.
- origin_x  in  8  cell origin x; latched on accept.
- origin_y  in  8  cell origin y; latched on accept.
- char_code  in  6  character select; latched on accept.
- busy  out  1  high from the cycle after accept through the DONE cycle inclusive.
- done  out  1  one-cycle pulse when the last plot has been accepted.
- char_sel  out  6  latched char_code to the decoder mux; stable while busy.
- char_x  out  8  latched origin_x to the decoder x input.
- char_y  out  8  latched origin_y to the decoder y input.
- scan_x  out  8  origin_x + dx, mod 256, to the decoder flush_x input.
- scan_y  out  8  origin_y + dy, mod 256, to the decoder flush_y input.
- glyph_enable  in  1  decoder pixel-set, combinational from scan_*.
- glyph_colour  in  6  decoder colour, combinational from scan_*.
- vga_x  out  8  plot x (registered).
- vga_y  out  8  plot y (registered).
- vga_colour  out  6  plot colour (registered).
- vga_plot  out  1  plot valid.
- vga_ready  in  1  adapter accepts a plot when vga_plot && vga_ready.

Behaviour:
- Reset (synchronous, active-high, takes priority over everything including mid-blit):
  - state=IDLE, dx=dy=0.
  - busy=0, done=0, vga_plot=0.
  - vga_x/vga_y/vga_colour=0, char_sel/char_x/char_y=0.
  - Any in-flight plot is dropped.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - start=1 latches origin_x, origin_y and char_code, clears dx and dy, then goes to SCAN.
  - start in any other state is ignored and is not queued.
- SCAN, each cycle:
  - scan_x = char_x + dx and scan_y = char_y + dy, combinational from the counters, 8-bit wrap.
  - The output register is free when vga_plot==0 or vga_ready==1.
  - If free, glyph_enable is sampled:
    - enable=1: load vga_x/vga_y=scan_x/scan_y, vga_colour=glyph_colour, vga_plot=1.
    - enable=0 with CLEAR_BG=1: same load, but vga_colour=BG_COLOUR.
    - Otherwise: vga_plot=0 if the previous plot was accepted.
    - Then advance: dx++; when dx==CELL_W-1, dx=0 and dy++.
  - If not free (stall), counters and output registers hold; scan_x/scan_y stay stable.
  - After sampling pixel (CELL_W-1, CELL_H-1), go to DRAIN.
- DRAIN: when vga_plot==0, or vga_plot && vga_ready, clear vga_plot and go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- vga_x/vga_y/vga_colour must not change while vga_plot=1 && vga_ready=0.
- Latency with vga_ready held at 1:
  - start accepted in cycle 0.
  - Pixel k (0..CELL_W*CELL_H-1) sampled in cycle k+1; its plot is visible in cycle k+2.
  - done in cycle CELL_W*CELL_H+2, i.e. cycle 82 at the defaults.
- Every stall cycle delays done by one cycle.
- The glyph decoder is purely combinational; no extra wait state.

Decomposition:
- Shared package holds:
  - default cell constants CELL_W=8 and CELL_H=10;
  - COLOUR_W=6 and COORD_W=8;
  - the state encoding (IDLE, SCAN, DRAIN, DONE).
- One natural sub-module, cell_scan_counter: dx/dy counter with enable, clear and a last-pixel flag.
- The FSM and output register stay in char_blitter.

Test Plan:
- char_k attached, origin (0x10,0x20), vga_ready=1 -> exactly 21 plots, first at (0x12,0x20); done pulses in cycle 82; busy high cycles 1..82.
- Same setup with CLEAR_BG=1, BG_COLOUR=6'h05 -> 80 plots in row-major order; the 59 unset pixels carry colour 0x05.
- vga_ready=0 for 5 cycles while the first plot is pending -> vga_x/vga_y/vga_colour and scan_x stable; done moves to cycle 87.
- origin (0xFC,0xFA) -> scan_x wraps 0xFC..0x03 and scan_y wraps 0xFA..0x03; the plot set matches the no-wrap case, translated.
- start re-pulsed during SCAN, then reset asserted at cycle 30 -> second start ignored; next cycle vga_plot=0, busy=0, no done; a new start then blits normally.
- start held high continuously -> blits run back to back; each new accept happens only in the IDLE cycle after DONE.

Source files
------------

// File: rtl/char_blitter_pkg.sv
// rtl/char_blitter_pkg.sv - shared constants and state encoding for the character blitter
//
// Purpose: default cell geometry, datapath widths and the blitter FSM encoding,
//          shared by char_blitter and its scan counter.
// Ports:   none (package).

package char_blitter_pkg;

    localparam int CELL_W_DEF = 8;
    localparam int CELL_H_DEF = 10;
    localparam int COLOUR_W   = 6;
    localparam int COORD_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } blit_state_t;

endpackage

// File: rtl/char_blitter_cell_scan_counter.sv
// rtl/char_blitter_cell_scan_counter.sv - row-major dx/dy walker over one character cell
//
// Purpose: steps (dx, dy) through a CELL_W x CELL_H cell, one pixel per enabled cycle.
// Ports:
//   i_clock   system clock
//   i_reset   synchronous active-high reset
//   i_clear   return to pixel (0,0)
//   i_enable  advance to the next pixel
//   o_dx      current column within the cell
//   o_dy      current row within the cell
//   o_last    current pixel is (CELL_W-1, CELL_H-1)

module char_blitter_cell_scan_counter
    import char_blitter_pkg::*;
#(
    parameter int CELL_W = CELL_W_DEF,
    parameter int CELL_H = CELL_H_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_enable,
    output logic [COORD_W-1:0] o_dx,
    output logic [COORD_W-1:0] o_dy,
    output logic               o_last
);

    logic [COORD_W-1:0] r_dx;
    logic [COORD_W-1:0] r_dy;
    logic               w_row_end;

    assign w_row_end = (r_dx == COORD_W'(CELL_W - 1));
    assign o_last    = w_row_end && (r_dy == COORD_W'(CELL_H - 1));
    assign o_dx      = r_dx;
    assign o_dy      = r_dy;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_dx <= '0;
            r_dy <= '0;
        end else if (i_enable) begin
            if (w_row_end) begin
                r_dx <= '0;
                // Wrap back to the origin after the last pixel so the counter
                // never leaves the cell even if left enabled.
                r_dy <= o_last ? '0 : r_dy + COORD_W'(1);
            end else begin
                r_dx <= r_dx + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/char_blitter.sv
// rtl/char_blitter.sv - walks one character cell and emits plot writes to the VGA adapter
//
// Purpose: on start, latches origin and char code, presents each pixel of the cell to the
//          glyph decoder bank and forwards set (or background) pixels as plot writes
//          over a valid/ready handshake.
// Ports:
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_start                   blit request (accepted only in IDLE)
//   i_origin_x/y, i_char_code cell origin and character select, latched on accept
//   o_busy, o_done            busy through DONE cycle; one-cycle completion pulse
//   o_char_sel, o_char_x/y    latched character select and origin to the decoders
//   o_scan_x/y                absolute coordinates of the pixel being presented
//   i_glyph_enable/colour     decoder response for the presented pixel
//   o_vga_x/y/colour          registered plot data
//   o_vga_plot, i_vga_ready   plot valid / adapter ready

module char_blitter
    import char_blitter_pkg::*;
#(
    parameter int                  CELL_W    = CELL_W_DEF,
    parameter int                  CELL_H    = CELL_H_DEF,
    parameter bit                  CLEAR_BG  = 1'b0,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [COORD_W-1:0]  i_origin_x,
    input  logic [COORD_W-1:0]  i_origin_y,
    input  logic [COLOUR_W-1:0] i_char_code,
    output logic                o_busy,
    output logic                o_done,
    output logic [COLOUR_W-1:0] o_char_sel,
    output logic [COORD_W-1:0]  o_char_x,
    output logic [COORD_W-1:0]  o_char_y,
    output logic [COORD_W-1:0]  o_scan_x,
    output logic [COORD_W-1:0]  o_scan_y,
    input  logic                i_glyph_enable,
    input  logic [COLOUR_W-1:0] i_glyph_colour,
    output logic [COORD_W-1:0]  o_vga_x,
    output logic [COORD_W-1:0]  o_vga_y,
    output logic [COLOUR_W-1:0] o_vga_colour,
    output logic                o_vga_plot,
    input  logic                i_vga_ready
);

    blit_state_t         r_state;
    logic                r_busy;
    logic                r_done;
    logic [COLOUR_W-1:0] r_char_sel;
    logic [COORD_W-1:0]  r_char_x;
    logic [COORD_W-1:0]  r_char_y;
    logic [COORD_W-1:0]  r_vga_x;
    logic [COORD_W-1:0]  r_vga_y;
    logic [COLOUR_W-1:0] r_vga_colour;
    logic                r_vga_plot;

    logic [COORD_W-1:0]  w_dx;
    logic [COORD_W-1:0]  w_dy;
    logic                w_last;
    logic                w_free;
    logic                w_accept;
    logic                w_step;

    // Output register can take a new pixel when empty or being consumed this cycle.
    assign w_free   = !r_vga_plot || i_vga_ready;
    assign w_accept = (r_state == ST_IDLE) && i_start;
    assign w_step   = (r_state == ST_SCAN) && w_free;

    char_blitter_cell_scan_counter #(
        .CELL_W (CELL_W),
        .CELL_H (CELL_H)
    ) u_scan (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_clear  (w_accept),
        .i_enable (w_step),
        .o_dx     (w_dx),
        .o_dy     (w_dy),
        .o_last   (w_last)
    );

    // Counters hold on a stall, so the decoder inputs stay stable with them.
    assign o_scan_x = r_char_x + w_dx;
    assign o_scan_y = r_char_y + w_dy;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_char_sel   <= '0;
            r_char_x     <= '0;
            r_char_y     <= '0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_char_sel <= i_char_code;
                        r_char_x   <= i_origin_x;
                        r_char_y   <= i_origin_y;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_free) begin
                        if (i_glyph_enable || CLEAR_BG) begin
                            r_vga_x      <= o_scan_x;
                            r_vga_y      <= o_scan_y;
                            r_vga_colour <= i_glyph_enable ? i_glyph_colour : BG_COLOUR;
                            r_vga_plot   <= 1'b1;
                        end else begin
                            r_vga_plot   <= 1'b0;
                        end
                        if (w_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Wait for the final plot to be taken before signalling completion.
                    if (w_free) begin
                        r_vga_plot <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_char_sel   = r_char_sel;
    assign o_char_x     = r_char_x;
    assign o_char_y     = r_char_y;
    assign o_vga_x      = r_vga_x;
    assign o_vga_y      = r_vga_y;
    assign o_vga_colour = r_vga_colour;
    assign o_vga_plot   = r_vga_plot;

endmodule

// File: tb/tb_char_blitter.sv
// tb/tb_char_blitter.sv - scoreboard bench for char_blitter with a 'K' glyph decoder model

module tb_char_blitter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, bg_start, ready, bg_ready;
    logic [7:0] ox, oy;
    logic [5:0] code;

    logic       busy, done, plot, en;
    logic [5:0] csel, vcol, col;
    logic [7:0] cx, cy, sx, sy, vx, vy;

    logic       bg_busy, bg_done, bg_plot, bg_en;
    logic [5:0] bg_csel, bg_vcol, bg_col;
    logic [7:0] bg_cx, bg_cy, bg_sx, bg_sy, bg_vx, bg_vy;

    char_blitter u_dut (
        .i_clock(clk), .i_reset(rst), .i_start(start),
        .i_origin_x(ox), .i_origin_y(oy), .i_char_code(code),
        .o_busy(busy), .o_done(done), .o_char_sel(csel),
        .o_char_x(cx), .o_char_y(cy), .o_scan_x(sx), .o_scan_y(sy),
        .i_glyph_enable(en), .i_glyph_colour(col),
        .o_vga_x(vx), .o_vga_y(vy), .o_vga_colour(vcol),
        .o_vga_plot(plot), .i_vga_ready(ready)
    );

    char_blitter #(.CLEAR_BG(1'b1), .BG_COLOUR(6'h05)) u_dut_bg (
        .i_clock(clk), .i_reset(rst), .i_start(bg_start),
        .i_origin_x(ox), .i_origin_y(oy), .i_char_code(code),
        .o_busy(bg_busy), .o_done(bg_done), .o_char_sel(bg_csel),
        .o_char_x(bg_cx), .o_char_y(bg_cy), .o_scan_x(bg_sx), .o_scan_y(bg_sy),
        .i_glyph_enable(bg_en), .i_glyph_colour(bg_col),
        .o_vga_x(bg_vx), .o_vga_y(bg_vy), .o_vga_colour(bg_vcol),
        .o_vga_plot(bg_plot), .i_vga_ready(bg_ready)
    );

    // 'K' bitmap, bit index = dx; 21 set pixels, first at dx=2 of row 0.
    function automatic logic [7:0] glyph_row(input logic [7:0] r);
        case (r)
            8'd0: return 8'h44;
            8'd1: return 8'h24;
            8'd2: return 8'h14;
            8'd3: return 8'h0C;
            8'd4: return 8'h0C;
            8'd5: return 8'h14;
            8'd6: return 8'h24;
            8'd7: return 8'h44;
            8'd8: return 8'h44;
            8'd9: return 8'h0E;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic px_set(input logic [7:0] bx, by, px, py);
        logic [7:0] ddx, ddy, row;
        ddx = px - bx;
        ddy = py - by;
        if (ddx < 8'd8 && ddy < 8'd10) begin
            row = glyph_row(ddy);
            return row[ddx[2:0]];
        end
        return 1'b0;
    endfunction

    // Glyph colour always has bit 5 set, so it can never be mistaken for 0x05.
    function automatic logic [5:0] px_col(input logic [5:0] c, input logic [7:0] ddx, ddy);
        return {1'b1, c[1:0] ^ ddy[1:0], ddx[2:0]};
    endfunction

    always_comb begin
        en     = px_set(cx, cy, sx, sy);
        col    = px_col(csel, sx - cx, sy - cy);
        bg_en  = px_set(bg_cx, bg_cy, bg_sx, bg_sy);
        bg_col = px_col(bg_csel, bg_sx - bg_cx, bg_sy - bg_cy);
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [21:0] sb_q[$];
    logic [21:0] bg_q[$];

    task automatic push_blit(input logic [7:0] x0, input logic [7:0] y0,
                             input logic [5:0] c, input bit bg);
        logic [7:0]  row;
        logic [21:0] e;
        for (int dy = 0; dy < 10; dy++) begin
            row = glyph_row(8'(dy));
            for (int dx = 0; dx < 8; dx++) begin
                if (row[dx]) e = {8'(x0 + dx), 8'(y0 + dy), px_col(c, 8'(dx), 8'(dy))};
                else         e = {8'(x0 + dx), 8'(y0 + dy), 6'h05};
                if (row[dx] || bg) begin
                    if (bg) bg_q.push_back(e);
                    else    sb_q.push_back(e);
                end
            end
        end
    endtask

    int          cyc = 0;
    int          n_plots = 0, acc_cyc = 0, done_cyc = 0, done_cnt = 0, busy_cyc = 0;
    int          bg_plots = 0, bg_col5 = 0;
    logic        prev_busy = 1'b0;
    logic [21:0] first_plot = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (busy && !prev_busy) begin
                acc_cyc  = cyc - 1;
                n_plots  = 0;
                busy_cyc = 0;
            end
            if (busy) busy_cyc++;
            if (plot && ready) begin
                if (n_plots == 0) first_plot = {vx, vy, vcol};
                n_plots++;
                if (sb_q.size() == 0) check("sb_underflow", 0, 1);
                else                  check("plot", {vx, vy, vcol}, sb_q.pop_front());
            end
            if (done) begin
                done_cyc = cyc;
                done_cnt++;
            end
            if (bg_plot && bg_ready) begin
                bg_plots++;
                if (bg_vcol == 6'h05) bg_col5++;
                if (bg_q.size() == 0) check("bg_sb_underflow", 0, 1);
                else                  check("bg_plot", {bg_vx, bg_vy, bg_vcol}, bg_q.pop_front());
            end
        end
        prev_busy = busy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] x, input logic [7:0] y,
                            input logic [5:0] c, output int t0);
        tick();
        ox = x; oy = y; code = c; start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int prev_cnt);
        int n;
        n = 0;
        while (done_cnt == prev_cnt && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("done_seen", done_cnt != prev_cnt, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int t0, dc, d1;
        rst = 1'b1; start = 1'b0; bg_start = 1'b0; ready = 1'b1; bg_ready = 1'b1;
        ox = 8'h00; oy = 8'h00; code = 6'h00;
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_plot", plot, 0);
        check("rst_vga", {vx, vy, vcol}, 0);
        check("rst_char", {csel, cx, cy}, 0);
        tick();
        rst = 1'b0;

        // Normal blit on both instances, ready held high.
        push_blit(8'h10, 8'h20, 6'h0B, 1'b0);
        push_blit(8'h10, 8'h20, 6'h0B, 1'b1);
        dc = done_cnt;
        tick();
        ox = 8'h10; oy = 8'h20; code = 6'h0B; start = 1'b1; bg_start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0; bg_start = 1'b0;
        wait_done(dc);
        check("n1_plots", n_plots, 21);
        check("n1_first", first_plot, {8'h12, 8'h20, px_col(6'h0B, 8'd2, 8'd0)});
        check("n1_accept", acc_cyc, t0);
        check("n1_done_cycle", done_cyc - t0, 82);
        check("n1_busy_cycles", busy_cyc, 82);
        @(negedge clk);
        check("n1_done_pulse", done, 0);
        check("n1_busy_after", busy, 0);
        check("n1_sb_empty", sb_q.size(), 0);
        repeat (3) tick();
        check("bg_plots", bg_plots, 80);
        check("bg_col5", bg_col5, 59);
        check("bg_sb_empty", bg_q.size(), 0);

        // Stall the first plot for 5 cycles.
        push_blit(8'h30, 8'h40, 6'h15, 1'b0);
        dc = done_cnt;
        do_start(8'h30, 8'h40, 6'h15, t0);
        repeat (3) tick();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_plot", plot, 1);
            check("stall_vga", {vx, vy, vcol}, {8'h32, 8'h40, px_col(6'h15, 8'd2, 8'd0)});
            check("stall_scan", {sx, sy}, {8'h33, 8'h40});
            tick();
        end
        ready = 1'b1;
        wait_done(dc);
        check("stall_done_cycle", done_cyc - t0, 87);
        check("stall_plots", n_plots, 21);
        check("stall_sb_empty", sb_q.size(), 0);

        // Origin near the top of the coordinate range: scan wraps mod 256.
        push_blit(8'hFC, 8'hFA, 6'h2A, 1'b0);
        dc = done_cnt;
        do_start(8'hFC, 8'hFA, 6'h2A, t0);
        @(negedge clk);
        check("wrap_scan_p0", {sx, sy}, {8'hFC, 8'hFA});
        repeat (4) tick();
        @(negedge clk);
        check("wrap_scan_p4", {sx, sy}, {8'h00, 8'hFA});
        repeat (68) tick();
        @(negedge clk);
        check("wrap_scan_p72", {sx, sy}, {8'hFC, 8'h03});
        repeat (7) tick();
        @(negedge clk);
        check("wrap_scan_p79", {sx, sy}, {8'h03, 8'h03});
        wait_done(dc);
        check("wrap_done_cycle", done_cyc - t0, 82);
        check("wrap_plots", n_plots, 21);
        check("wrap_sb_empty", sb_q.size(), 0);

        // Re-pulsed start during SCAN, then reset mid-blit.
        push_blit(8'h10, 8'h20, 6'h0B, 1'b0);
        do_start(8'h10, 8'h20, 6'h0B, t0);
        repeat (4) tick();
        ox = 8'h50; oy = 8'h60; start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("restart_ignored", {cx, cy}, {8'h10, 8'h20});
        check("restart_busy", busy, 1);
        repeat (24) tick();
        check("rst_at_cycle", cyc - t0, 30);
        rst = 1'b1;
        dc = done_cnt;
        tick();
        @(negedge clk);
        check("midrst_plot", plot, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        tick();
        rst = 1'b0;
        sb_q.delete();
        repeat (100) tick();
        check("midrst_no_done", done_cnt, dc);
        check("midrst_idle", busy, 0);
        push_blit(8'h44, 8'h55, 6'h07, 1'b0);
        do_start(8'h44, 8'h55, 6'h07, t0);
        wait_done(dc);
        check("post_rst_done_cycle", done_cyc - t0, 82);
        check("post_rst_plots", n_plots, 21);
        check("post_rst_sb_empty", sb_q.size(), 0);

        // Start held high: back-to-back blits, re-accept in the IDLE cycle after DONE.
        push_blit(8'h08, 8'h09, 6'h01, 1'b0);
        dc = done_cnt;
        tick();
        ox = 8'h08; oy = 8'h09; code = 6'h01; start = 1'b1;
        t0 = cyc;
        wait_done(dc);
        check("b2b_done1_cycle", done_cyc - t0, 82);
        d1 = done_cyc;
        push_blit(8'h08, 8'h09, 6'h01, 1'b0);
        dc = done_cnt;
        wait_done(dc);
        start = 1'b0;
        check("b2b_accept2", acc_cyc, d1 + 1);
        check("b2b_done2_cycle", done_cyc - acc_cyc, 82);
        check("b2b_plots2", n_plots, 21);
        repeat (5) tick();
        check("b2b_stopped", busy, 0);
        check("b2b_done_count", done_cnt, dc + 1);
        check("b2b_sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
